// File: rtl/fft_pkg.sv
// Shared types and constants for the small-point FFT/IFFT datapath blocks.
// Holds the complex sample type, stream FSM states and the round/scale helpers.
package fft_pkg;

  localparam int FFT_W = 12;
  localparam int RND   = 2;
  localparam int SHIFT = 2;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CALC  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic signed [FFT_W+1:0] ext2(input logic signed [FFT_W-1:0] v);
    return {{2{v[FFT_W-1]}}, v};
  endfunction

  // One extra guard bit so the +RND never wraps before the arithmetic shift.
  function automatic logic signed [FFT_W-1:0] rnd_scale(input logic signed [FFT_W+1:0] s);
    logic signed [FFT_W+2:0] t;
    t = {s[FFT_W+1], s} + (FFT_W+3)'(RND);
    return FFT_W'(t >>> SHIFT);
  endfunction

endpackage

// File: rtl/ifft4_core.sv
// Combinational 4-point inverse DFT butterfly with round-half-up divide by 4.
// Twiddles are +j powers, so only adds/subtracts and re/im swaps are needed.
module ifft4_core
  import fft_pkg::*;
(
  input  cplx_t i_x0,
  input  cplx_t i_x1,
  input  cplx_t i_x2,
  input  cplx_t i_x3,
  output cplx_t o_y0,
  output cplx_t o_y1,
  output cplx_t o_y2,
  output cplx_t o_y3
);

  logic signed [FFT_W+1:0] w_a0r, w_a0i, w_a1r, w_a1i, w_a2r, w_a2i, w_a3r, w_a3i;
  logic signed [FFT_W+1:0] w_s0r, w_s0i, w_s1r, w_s1i, w_s2r, w_s2i, w_s3r, w_s3i;

  assign w_a0r = ext2(i_x0.re);
  assign w_a0i = ext2(i_x0.im);
  assign w_a1r = ext2(i_x1.re);
  assign w_a1i = ext2(i_x1.im);
  assign w_a2r = ext2(i_x2.re);
  assign w_a2i = ext2(i_x2.im);
  assign w_a3r = ext2(i_x3.re);
  assign w_a3i = ext2(i_x3.im);

  assign w_s0r = w_a0r + w_a1r + w_a2r + w_a3r;
  assign w_s0i = w_a0i + w_a1i + w_a2i + w_a3i;
  assign w_s1r = w_a0r - w_a2r - w_a1i + w_a3i;
  assign w_s1i = w_a0i - w_a2i + w_a1r - w_a3r;
  assign w_s2r = w_a0r - w_a1r + w_a2r - w_a3r;
  assign w_s2i = w_a0i - w_a1i + w_a2i - w_a3i;
  assign w_s3r = w_a0r - w_a2r + w_a1i - w_a3i;
  assign w_s3i = w_a0i - w_a2i - w_a1r + w_a3r;

  assign o_y0 = '{re: rnd_scale(w_s0r), im: rnd_scale(w_s0i)};
  assign o_y1 = '{re: rnd_scale(w_s1r), im: rnd_scale(w_s1i)};
  assign o_y2 = '{re: rnd_scale(w_s2r), im: rnd_scale(w_s2i)};
  assign o_y3 = '{re: rnd_scale(w_s3r), im: rnd_scale(w_s3i)};

endmodule

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse DFT: collects one frame, transforms it, drains it.
//   state    | meaning
//   ST_LOAD  | accepting X0..X3 into the frame registers (in_ready high)
//   ST_CALC  | one cycle: butterfly result latched into the output buffer
//   ST_DRAIN | presenting x0..x3 on the output stream (out_valid high)
module ifft4_stream
  import fft_pkg::*;
#(
  parameter int W = FFT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic [1:0]          out_idx,
  output logic                out_last
);

  state_t     r_state;
  logic [1:0] r_in_cnt;
  logic [1:0] r_out_cnt;
  cplx_t      r_frame [4];
  cplx_t      r_obuf  [4];
  cplx_t      w_y0, w_y1, w_y2, w_y3;

  ifft4_core u_core (
    .i_x0 (r_frame[0]),
    .i_x1 (r_frame[1]),
    .i_x2 (r_frame[2]),
    .i_x3 (r_frame[3]),
    .o_y0 (w_y0),
    .o_y1 (w_y1),
    .o_y2 (w_y2),
    .o_y3 (w_y3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_LOAD;
      r_in_cnt  <= 2'd0;
      r_out_cnt <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_frame[i] <= '0;
        r_obuf[i]  <= '0;
      end
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            r_frame[r_in_cnt] <= '{re: in_re, im: in_im};
            r_in_cnt          <= r_in_cnt + 2'd1;
            if (r_in_cnt == 2'd3) r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_obuf[0] <= w_y0;
          r_obuf[1] <= w_y1;
          r_obuf[2] <= w_y2;
          r_obuf[3] <= w_y3;
          r_out_cnt <= 2'd0;
          r_state   <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_ready) begin
            r_out_cnt <= r_out_cnt + 2'd1;
            if (r_out_cnt == 2'd3) r_state <= ST_LOAD;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  // Output view is a mux over the buffer, so it holds for free under backpressure.
  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_DRAIN);
  assign out_idx   = r_out_cnt;
  assign out_last  = out_valid && (r_out_cnt == 2'd3);
  assign out_re    = r_obuf[r_out_cnt].re;
  assign out_im    = r_obuf[r_out_cnt].im;

endmodule
